// File: rtl/csr_gpio_debounce.sv
// csr_gpio_debounce: CSR-mapped GPIO bank with per-channel synchroniser, debounce filter,
// edge detection and maskable level interrupt.
module csr_gpio_debounce #(
    parameter logic [3:0]     csr_addr      = 4'h0,
    parameter int             ninputs       = 8,
    parameter int             noutputs      = 8,
    parameter int             dbw           = 20,
    parameter logic [dbw-1:0] debounce_init = dbw'(125000)
) (
    input  logic                sys_clk,
    input  logic                sys_rst,
    input  logic [13:0]         csr_a,
    input  logic                csr_we,
    input  logic [31:0]         csr_di,
    output logic [31:0]         csr_do,
    input  logic [ninputs-1:0]  gpio_inputs,
    output logic [noutputs-1:0] gpio_outputs,
    output logic                irq
);
    logic [ninputs-1:0]  sync1_q, sync_q, deb_q, deb_d;
    logic [ninputs-1:0]  rise_en_q, fall_en_q, pend_q, pend_d, clr;
    logic [dbw-1:0]      cnt_q [ninputs];
    logic [dbw-1:0]      cnt_d [ninputs];
    logic [noutputs-1:0] out_q;
    logic [dbw-1:0]      thr_q;
    logic [31:0]         do_q, rd_data;
    logic                irq_q, sel, we;
    logic [2:0]          idx;
    logic                unused_ok;

    assign sel       = csr_a[13:10] == csr_addr;
    assign we        = sel & csr_we;
    assign idx       = csr_a[2:0];
    assign unused_ok = ^{csr_a[9:3], csr_di};

    // Compare before incrementing so the counter can never wrap past the threshold.
    always_comb begin
        deb_d = deb_q;
        cnt_d = cnt_q;
        for (int i = 0; i < ninputs; i++) begin
            if (sync_q[i] == deb_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] >= thr_q) begin
                deb_d[i] = sync_q[i];
                cnt_d[i] = '0;
            end else begin
                cnt_d[i] = cnt_q[i] + dbw'(1);
            end
        end
    end

    // A new event in the same cycle as a clear keeps the bit set.
    assign clr    = (we && idx == 3'd4) ? csr_di[ninputs-1:0] : '0;
    assign pend_d = (pend_q & ~clr) | (deb_d & ~deb_q & rise_en_q) | (~deb_d & deb_q & fall_en_q);

    always_comb begin
        case (idx)
            3'd0:    rd_data = 32'(deb_q);
            3'd1:    rd_data = 32'(out_q);
            3'd2:    rd_data = 32'(rise_en_q);
            3'd3:    rd_data = 32'(fall_en_q);
            3'd4:    rd_data = 32'(pend_q);
            3'd5:    rd_data = 32'(thr_q);
            3'd6:    rd_data = 32'(sync_q);
            default: rd_data = '0;
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            sync1_q   <= '0;
            sync_q    <= '0;
            deb_q     <= '0;
            cnt_q     <= '{default: '0};
            out_q     <= '0;
            rise_en_q <= '0;
            fall_en_q <= '0;
            pend_q    <= '0;
            thr_q     <= debounce_init;
            do_q      <= '0;
            irq_q     <= 1'b0;
        end else begin
            sync1_q <= gpio_inputs;
            sync_q  <= sync1_q;
            deb_q   <= deb_d;
            cnt_q   <= cnt_d;
            pend_q  <= pend_d;
            irq_q   <= |pend_d;
            do_q    <= sel ? rd_data : '0;
            if (we && idx == 3'd1) out_q <= csr_di[noutputs-1:0];
            if (we && idx == 3'd2) rise_en_q <= csr_di[ninputs-1:0];
            if (we && idx == 3'd3) fall_en_q <= csr_di[ninputs-1:0];
            if (we && idx == 3'd5) thr_q <= csr_di[dbw-1:0];
        end
    end

    assign csr_do       = do_q;
    assign gpio_outputs = out_q;
    assign irq          = irq_q;
endmodule
